// File: rtl/dvp_emu_pkg.sv
// Shared types and constants for the synthetic DVP camera source.
// Holds the frame state encoding, pattern mode codes and the colour-bar palette.
package dvp_emu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVbp,
        StActive,
        StVfp
    } dvp_state_e;

    localparam logic [1:0] ModeBars  = 2'd0;
    localparam logic [1:0] ModeSolid = 2'd1;
    localparam logic [1:0] ModeRamp  = 2'd2;
    localparam logic [1:0] ModeCoord = 2'd3;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        bar_color = 16'h0000;
        unique case (idx)
            3'd0: bar_color = 16'hFFFF;
            3'd1: bar_color = 16'hFFE0;
            3'd2: bar_color = 16'h07FF;
            3'd3: bar_color = 16'h07E0;
            3'd4: bar_color = 16'hF81F;
            3'd5: bar_color = 16'hF800;
            3'd6: bar_color = 16'h001F;
            3'd7: bar_color = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Test-pattern pixel generator: produces one registered RGB565 pixel per step.
// Colour bars are tracked with a per-line bar counter instead of dividing x.
module dvp_pattern_gen
    import dvp_emu_pkg::*;
#(
    parameter int unsigned H_RES = 800
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        step_i,
    input  logic        first_i,
    input  logic [15:0] x_i,
    input  logic [5:0]  y_i,
    input  logic [1:0]  mode_i,
    input  logic [15:0] solid_i,
    input  logic [4:0]  frame_cnt_i,
    output logic [15:0] pixel_o
);

    localparam int unsigned BarW = H_RES / 8;
    localparam int unsigned BW   = (BarW > 1) ? $clog2(BarW) : 1;
    localparam logic [BW-1:0] BarLast = BW'(BarW - 1);
    localparam logic [BW-1:0] BarOne  = BW'(1);

    logic [2:0]    bar_idx_q, bar_idx_d, cur_idx;
    logic [BW-1:0] bar_px_q, bar_px_d, cur_px;
    logic [15:0]   pixel_q, pixel_d;

    always_comb begin
        cur_idx   = first_i ? 3'd0 : bar_idx_q;
        cur_px    = first_i ? '0 : bar_px_q;
        bar_idx_d = bar_idx_q;
        bar_px_d  = bar_px_q;
        pixel_d   = pixel_q;
        if (step_i) begin
            if (cur_px == BarLast) begin
                bar_px_d  = '0;
                bar_idx_d = cur_idx + 3'd1;
            end else begin
                bar_px_d  = cur_px + BarOne;
                bar_idx_d = cur_idx;
            end
            unique case (mode_i)
                ModeBars:  pixel_d = bar_color(cur_idx);
                ModeSolid: pixel_d = solid_i;
                ModeRamp:  pixel_d = x_i;
                ModeCoord: pixel_d = {frame_cnt_i, y_i, x_i[4:0]};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_idx_q <= '0;
            bar_px_q  <= '0;
            pixel_q   <= '0;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_px_q  <= bar_px_d;
            pixel_q   <= pixel_d;
        end
    end

    assign pixel_o = pixel_q;

endmodule

// File: rtl/dvp_cam_emu.sv
// Synthetic OV2640-style DVP source: frame timing FSM, counters and byte serialisation.
// One RGB565 byte per clock, high byte first; all outputs are registered.
module dvp_cam_emu
    import dvp_emu_pkg::*;
#(
    parameter int unsigned H_RES    = 800,
    parameter int unsigned V_RES    = 600,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned VS_LINES = 4,
    parameter int unsigned V_BPORCH = 8,
    parameter int unsigned V_FPORCH = 4,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic [1:0]  I_mode,
    input  logic [15:0] I_solid,
    output logic        O_vsync,
    output logic        O_href,
    output logic [9:0]  O_pixdata,
    output logic [15:0] O_frame_cnt,
    output logic        O_busy
);

    localparam int unsigned LineLen = 2 * H_RES + H_BLANK;
    localparam int unsigned HW      = $clog2(LineLen + 2);
    localparam logic [HW-1:0] LineLast = HW'(LineLen - 1);
    localparam logic [HW-1:0] LineLenC = HW'(LineLen);
    localparam logic [HW-1:0] ActBytes = HW'(2 * H_RES);
    localparam logic [HW-1:0] HOne     = HW'(1);
    localparam logic [HW-1:0] HTwo     = HW'(2);
    localparam logic [15:0]   VsLast   = 16'(VS_LINES - 1);
    localparam logic [15:0]   VbLast   = 16'(V_BPORCH - 1);
    localparam logic [15:0]   ActLast  = 16'(V_RES - 1);
    localparam logic [15:0]   VfLast   = 16'(V_FPORCH - 1);

    dvp_state_e    state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d, la, la_h;
    logic [15:0]   line_q, line_d, frame_cnt_q, frame_cnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   solid_q, solid_d, x_gen, y_gen, pixel;
    logic          vsync_q, vsync_d, href_q, href_d, busy_q, busy_d;
    logic [9:0]    pix_q, pix_d;
    logic [7:0]    pix_byte;
    logic          line_end, start, wrap, step, first;

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = '0;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        start       = 1'b0;
        line_end    = (h_cnt_q == LineLast);
        if (state_q != StIdle) begin
            h_cnt_d = line_end ? '0 : h_cnt_q + HOne;
            if (line_end) line_d = line_q + 16'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (I_en) begin
                    state_d = StVsync;
                    start   = 1'b1;
                end
            end
            StVsync: begin
                if (line_end && line_q == VsLast) begin
                    state_d = StVbp;
                    line_d  = '0;
                end
            end
            StVbp: begin
                if (line_end && line_q == VbLast) begin
                    state_d = StActive;
                    line_d  = '0;
                end
            end
            StActive: begin
                if (line_end && line_q == ActLast) begin
                    state_d = StVfp;
                    line_d  = '0;
                end
            end
            StVfp: begin
                if (line_end && line_q == VfLast) begin
                    line_d      = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (I_en) begin
                        state_d = StVsync;
                        start   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        mode_d  = start ? I_mode : mode_q;
        solid_d = start ? I_solid : solid_q;
    end

    // The generator works two bytes ahead so its registered pixel lines up with the byte mux.
    always_comb begin
        la    = h_cnt_q + HTwo;
        wrap  = (la >= LineLenC);
        la_h  = wrap ? la - LineLenC : la;
        x_gen = 16'(la_h[HW-1:1]);
        step  = !la_h[0] && (la_h < ActBytes);
        first = (la_h == '0);
        if (wrap) y_gen = (state_q == StActive) ? line_q + 16'd1 : 16'd0;
        else      y_gen = line_q;
    end

    dvp_pattern_gen #(
        .H_RES(H_RES)
    ) u_pattern_gen (
        .clk_i      (I_clk),
        .rst_ni     (I_rst_n),
        .step_i     (step),
        .first_i    (first),
        .x_i        (x_gen),
        .y_i        (y_gen[5:0]),
        .mode_i     (mode_q),
        .solid_i    (solid_q),
        .frame_cnt_i(frame_cnt_q[4:0]),
        .pixel_o    (pixel)
    );

    always_comb begin
        vsync_d  = (state_d == StVsync) ? VS_POL : ~VS_POL;
        href_d   = (state_d == StActive) && (h_cnt_d < ActBytes);
        busy_d   = (state_d != StIdle);
        pix_byte = h_cnt_d[0] ? pixel[7:0] : pixel[15:8];
        pix_d    = href_d ? {pix_byte, 2'b00} : 10'd0;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            h_cnt_q     <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            vsync_q     <= ~VS_POL;
            href_q      <= 1'b0;
            busy_q      <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            busy_q      <= busy_d;
            pix_q       <= pix_d;
        end
    end

    assign O_vsync     = vsync_q;
    assign O_href      = href_q;
    assign O_pixdata   = pix_q;
    assign O_frame_cnt = frame_cnt_q;
    assign O_busy      = busy_q;

endmodule

// File: tb/tb_dvp_cam_emu.sv
// Bench for dvp_cam_emu: frame-position reference model checked against every output each cycle.
// Directed scenarios (timing, patterns, enable drop, async reset, frame-count wrap) then random runs.
module tb_dvp_cam_emu;

    localparam int H_RES    = 16;
    localparam int V_RES    = 4;
    localparam int H_BLANK  = 8;
    localparam int VS_LINES = 2;
    localparam int V_BPORCH = 1;
    localparam int V_FPORCH = 1;
    localparam int LINE_LEN = 2 * H_RES + H_BLANK;
    localparam int FRAME    = LINE_LEN * (VS_LINES + V_BPORCH + V_RES + V_FPORCH);
    localparam int ACT0     = VS_LINES + V_BPORCH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] solid = 16'h0000;
    logic        vsync, href, busy;
    logic [9:0]  pixdata;
    logic [15:0] frame_cnt;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state: position within the current frame.
    bit          m_run;
    int          m_t;
    int          m_mode;
    logic [15:0] m_solid;
    logic [15:0] m_fcnt;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 clk = ~clk;

    dvp_cam_emu #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .H_BLANK (H_BLANK),
        .VS_LINES(VS_LINES),
        .V_BPORCH(V_BPORCH),
        .V_FPORCH(V_FPORCH),
        .VS_POL  (1'b0)
    ) dut (
        .I_clk      (clk),
        .I_rst_n    (rst_n),
        .I_en       (en),
        .I_mode     (mode),
        .I_solid    (solid),
        .O_vsync    (vsync),
        .O_href     (href),
        .O_pixdata  (pixdata),
        .O_frame_cnt(frame_cnt),
        .O_busy     (busy)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (t=%0d fcnt=%0d)", tag, got, exp, m_t, m_fcnt);
    endtask

    function automatic logic [15:0] ref_pixel(input int x, input int y);
        logic [15:0] xv, yv;
        xv = 16'(x);
        yv = 16'(y);
        case (m_mode)
            0:       return bars[x / (H_RES / 8)];
            1:       return m_solid;
            2:       return xv;
            default: return {m_fcnt[4:0], yv[5:0], xv[4:0]};
        endcase
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_t     = 0;
        m_mode  = 0;
        m_solid = 16'h0;
        m_fcnt  = 16'h0;
    endtask

    task automatic check_outputs();
        logic        e_vs, e_href;
        logic [9:0]  e_pix;
        logic [15:0] px;
        int          line, h;
        e_vs   = 1'b1;
        e_href = 1'b0;
        e_pix  = '0;
        if (m_run) begin
            line = m_t / LINE_LEN;
            h    = m_t % LINE_LEN;
            if (line < VS_LINES) e_vs = 1'b0;
            if (line >= ACT0 && line < ACT0 + V_RES && h < 2 * H_RES) begin
                e_href = 1'b1;
                px     = ref_pixel(h / 2, line - ACT0);
                e_pix  = {((h % 2) != 0) ? px[7:0] : px[15:8], 2'b00};
            end
        end
        chk("vsync", 16'(vsync), 16'(e_vs));
        chk("href", 16'(href), 16'(e_href));
        chk("pixdata", 16'(pixdata), 16'(e_pix));
        chk("busy", 16'(busy), 16'(m_run));
        chk("frame_cnt", frame_cnt, m_fcnt);
    endtask

    task automatic tick();
        logic        en_s;
        logic [1:0]  mode_s;
        logic [15:0] solid_s;
        en_s    = en;
        mode_s  = mode;
        solid_s = solid;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (m_run && m_t != FRAME - 1) begin
            m_t++;
        end else begin
            if (m_run) m_fcnt++;
            m_run = en_s;
            m_t   = 0;
            if (en_s) begin
                m_mode  = int'(mode_s);
                m_solid = solid_s;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int vs_low, rises, first_rise, vs_rel;
        logic href_prev;
        model_reset();

        // Reset state
        ticks(3);

        // Frame timing with bars; mode change mid-frame must not affect this frame
        en = 1'b1;
        mode = 2'd0;
        rst_n = 1'b1;
        vs_low = 0; rises = 0; first_rise = -1; vs_rel = -1;
        href_prev = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (vsync == 1'b0) vs_low++;
            if (vsync == 1'b1 && vs_low > 0 && vs_rel < 0) vs_rel = i;
            if (href && !href_prev) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            href_prev = href;
            if (i == 100) begin
                mode  = 2'd1;
                solid = 16'hA55A;
            end
        end
        chk("vsync_low_cycles", 16'(vs_low), 16'd80);
        chk("href_pulses", 16'(rises), 16'd4);
        chk("href_after_vsync", 16'(first_rise - vs_rel), 16'd40);
        tick();
        chk("frame_cnt_first", frame_cnt, 16'd1);

        // Solid frame, ramp requested mid-frame takes effect next frame
        ticks(150);
        mode = 2'd2;
        ticks(FRAME - 151 + FRAME);

        // Enable dropped during active line 2: frame completes, then idle
        mode  = 2'($urandom_range(0, 3));
        solid = 16'($urandom);
        ticks((ACT0 + 2) * LINE_LEN + 1);
        en = 1'b0;
        ticks(FRAME - (ACT0 + 2) * LINE_LEN + 20);
        chk("frame_cnt_after_drop", frame_cnt, 16'd4);
        chk("busy_after_drop", 16'(busy), 16'd0);

        // Async reset at active line 1, byte 5
        en    = 1'b1;
        mode  = 2'($urandom_range(0, 3));
        solid = 16'($urandom);
        ticks((ACT0 + 1) * LINE_LEN + 5 + 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_href", 16'(href), 16'd0);
        chk("rst_pixdata", 16'(pixdata), 16'd0);
        chk("rst_vsync", 16'(vsync), 16'd1);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        model_reset();
        ticks(3);
        rst_n = 1'b1;
        ticks(FRAME + 5);

        // Coordinate pattern across the frame_cnt[4:0] wrap
        mode = 2'd3;
        ticks(34 * FRAME);

        // Random modes, colours and enable toggling
        for (int k = 0; k < 10; k++) begin
            mode  = 2'($urandom_range(0, 3));
            solid = 16'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            ticks(int'($urandom_range(50, 450)));
        end
        en = 1'b0;
        ticks(FRAME + 10);
        chk("final_idle_busy", 16'(busy), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
